sram_controller: RTL and testbench

Sequencer between the MEM stage and the board's external 16-bit asynchronous SRAM. It converts one 32-bit load or store from the pipeline into two half-word SRAM accesses plus a programmable settle period. It drives `ready` low while an access is in flight so the pipeline freezes until the access completes. It sits under `TOP_LEVEL`, beside the MEM stage, and owns the `SRAM_*` pins.

---
 rtl/sram_controller_if.sv | 13 +
 rtl/sram_controller.sv | 102 ++++++++++
 tb/tb_sram_controller.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_if.sv
// Pipeline-side request/response bundle between the MEM stage and sram_controller.
// The MEM stage is the master; the controller answers with read_data and ready.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (output wr_en, rd_en, address, write_data, input read_data, ready);
  modport slave  (input wr_en, rd_en, address, write_data, output read_data, ready);
endinterface

// File: rtl/sram_controller.sv
// Splits one 32-bit load/store into two 16-bit async SRAM accesses plus a settle period,
// holding ready low until the access completes.
module sram_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  sram_controller_if.slave bus,
  inout  wire  [15:0]      SRAM_DQ,
  output logic [17:0]      SRAM_ADDR,
  output logic             SRAM_WE_N,
  output logic             SRAM_UB_N,
  output logic             SRAM_LB_N,
  output logic             SRAM_CE_N,
  output logic             SRAM_OE_N
);
  typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_WAIT, S_DONE} state_e;

  // Last counter value spent in WAIT; unused when WAIT_CYCLES is 0.
  localparam logic [2:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [17:0] addr_q, addr_d;
  logic [16:0] word_idx;
  logic        req;
  logic        drive;

  assign req      = bus.wr_en | bus.rd_en;
  assign word_idx = 17'((bus.address - BASE_ADDR) >> 2);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE: if (req) begin
        state_d = S_LOW;
        wr_d    = bus.wr_en;
        wdata_d = bus.write_data;
        addr_d  = {word_idx, 1'b0};
      end
      S_LOW: begin
        state_d = S_HIGH;
        addr_d  = {addr_q[17:1], 1'b1};
        if (!wr_q) rdata_d[15:0] = SRAM_DQ;
      end
      S_HIGH: begin
        wait_d  = 3'd0;
        state_d = (WAIT_CYCLES != 0) ? S_WAIT : S_DONE;
        if (!wr_q) rdata_d[31:16] = SRAM_DQ;
      end
      S_WAIT: begin
        wait_d = wait_q + 3'd1;
        if (wait_q == WAIT_LAST) begin
          state_d = S_DONE;
          wait_d  = 3'd0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= 3'd0;
      wr_q    <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      addr_q  <= 18'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
    end
  end

  // The bus is only ever driven during the two half-word phases of a store.
  assign drive     = wr_q & ((state_q == S_LOW) | (state_q == S_HIGH));
  assign SRAM_DQ   = drive ? ((state_q == S_LOW) ? wdata_q[15:0] : wdata_q[31:16]) : 16'bz;
  assign SRAM_WE_N = ~drive;
  assign SRAM_ADDR = addr_q;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  assign bus.read_data = rdata_q;
  assign bus.ready     = ~req | (state_q == S_DONE);
endmodule

// File: tb/tb_sram_controller.sv
// Randomized bench for sram_controller: two instances (W=2 and W=0) with behavioural SRAMs,
// checked against a word-level memory model and the documented latency.
module tb_sram_controller;
  localparam logic [31:0] BASE = 32'd1024;
  localparam int KEYS = 131072;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  sram_controller_if b0();
  sram_controller_if b1();

  wire  [15:0] dq0, dq1;
  logic [17:0] addr0, addr1;
  logic        we0, we1;
  logic        ub0, lb0, ce0, oe0, ub1, lb1, ce1, oe1;

  sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .bus(b0), .SRAM_DQ(dq0), .SRAM_ADDR(addr0), .SRAM_WE_N(we0),
    .SRAM_UB_N(ub0), .SRAM_LB_N(lb0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0));

  sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .bus(b1), .SRAM_DQ(dq1), .SRAM_ADDR(addr1), .SRAM_WE_N(we1),
    .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1));

  // Behavioural async SRAMs: output when not writing, capture while WE_N is low.
  logic [15:0] sram [0:1][0:262143];
  assign dq0 = we0 ? sram[0][addr0] : 16'bz;
  assign dq1 = we1 ? sram[1][addr1] : 16'bz;
  always @(posedge clk) begin
    if (!we0) sram[0][addr0] <= dq0;
    if (!we1) sram[1][addr1] <= dq1;
  end

  bit          sel;
  logic        o_rdy, o_we;
  logic [17:0] o_addr;
  logic [15:0] o_dq, o_mem;
  logic [31:0] o_rd;
  assign o_rdy  = sel ? b1.ready : b0.ready;
  assign o_we   = sel ? we1 : we0;
  assign o_addr = sel ? addr1 : addr0;
  assign o_dq   = sel ? dq1 : dq0;
  assign o_rd   = sel ? b1.read_data : b0.read_data;
  assign o_mem  = sram[sel][o_addr];

  int          n_chk, n_err;
  logic [31:0] ref_m [int];
  logic [31:0] exp_rd [0:1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int key_of(input logic [31:0] a);
    logic [31:0] d;
    d = a - BASE;
    return int'((d >> 2) & 32'h1FFFF);
  endfunction

  task automatic idle();
    b0.wr_en = 0; b0.rd_en = 0; b0.address = 0; b0.write_data = 0;
    b1.wr_en = 0; b1.rd_en = 0; b1.address = 0; b1.write_data = 0;
  endtask

  task automatic drive(input bit s, input bit wr, input bit rd, input logic [31:0] a,
                       input logic [31:0] wd);
    idle();
    if (s) begin b1.wr_en = wr; b1.rd_en = rd; b1.address = a; b1.write_data = wd; end
    else   begin b0.wr_en = wr; b0.rd_en = rd; b0.address = a; b0.write_data = wd; end
  endtask

  // One access, started in an IDLE cycle; n counts cycles of the request (IDLE is n=1).
  task automatic access(input bit s, input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] wd, input bit drop, input bit abort);
    int k, w, n;
    bit done;
    logic [17:0] lo;
    k  = key_of(a);
    lo = 18'(k * 2);
    w  = s ? 0 : 2;
    sel = s;
    drive(s, wr, rd, a, wd);
    n = 1;
    done = 0;
    while (!done) begin
      #1;
      if (n == 2 || n == 3) begin
        chk("we_n_access", 32'(o_we), wr ? 32'd0 : 32'd1);
        chk("sram_addr", 32'(o_addr), 32'(lo) + 32'(n - 2));
        if (wr) chk("dq_write", 32'(o_dq), (n == 2) ? 32'(wd[15:0]) : 32'(wd[31:16]));
        else    chk("dq_read_released", 32'(o_dq), 32'(o_mem));
        if (abort && n == 3) begin
          rst = 1;
          idle();
          @(negedge clk); #1;
          chk("abort_we_n", 32'(o_we), 32'd1);
          chk("abort_dq_released", 32'(o_dq), 32'(o_mem));
          chk("abort_ready", 32'(o_rdy), 32'd1);
          chk("abort_rdata", o_rd, 32'd0);
          rst = 0;
          exp_rd[0] = 0;
          exp_rd[1] = 0;
          return;
        end
      end else begin
        chk("we_n_quiet", 32'(o_we), 32'd1);
        chk("dq_released", 32'(o_dq), 32'(o_mem));
      end
      if (o_rdy) done = 1;
      else if (n >= 12) done = 1;
      else begin @(negedge clk); n++; end
    end
    chk("latency", 32'(n), 32'(4 + w));
    if (wr) ref_m[s * KEYS + k] = wd;
    else    exp_rd[s] = ref_m[s * KEYS + k];
    chk("rdata_done", o_rd, exp_rd[s]);
    @(negedge clk);
    if (drop) begin
      idle();
      #1;
      chk("rdata_held", o_rd, exp_rd[s]);
      chk("ready_after_drop", 32'(o_rdy), 32'd1);
    end
  endtask

  initial begin
    int klist [0:16];
    logic [31:0] d, a;
    int k, op;
    bit s;
    n_chk = 0;
    n_err = 0;
    sel = 0;
    for (int i = 0; i < 16; i++) klist[i] = i;
    klist[16] = 32'h1FFFF;
    for (int si = 0; si < 2; si++) begin
      for (int j = 0; j < 17; j++) begin
        d = $urandom;
        if (si == 0 && klist[j] == 1) d = 32'hDEADBEEF;
        ref_m[si * KEYS + klist[j]] = d;
        sram[si][2 * klist[j]]     <= d[15:0];
        sram[si][2 * klist[j] + 1] <= d[31:16];
      end
    end

    drive(0, 0, 1, 32'd1028, 32'd0);
    rst = 1;
    repeat (2) begin
      @(negedge clk); #1;
      chk("rst_rdata", o_rd, 32'd0);
      chk("rst_we_n", 32'(o_we), 32'd1);
      chk("rst_dq_released", 32'(o_dq), 32'(o_mem));
      chk("rst_addr_idle", 32'(o_addr), 32'd0);
      chk("rst_ready", 32'(o_rdy), 32'd0);
    end
    chk("tie_pins", {28'd0, ub0, lb0, ce0, oe0}, 32'd0);
    @(negedge clk);
    rst = 0;
    idle();
    exp_rd[0] = 0;
    exp_rd[1] = 0;
    @(negedge clk);

    access(0, 1, 0, 32'd1024, 32'h12345678, 1, 0);
    access(0, 0, 1, 32'd1028, 32'd0, 1, 0);
    access(0, 1, 1, 32'd1032, 32'hA5A50F0F, 1, 0);
    access(0, 1, 0, 32'd1076, $urandom, 0, 1);
    access(0, 0, 1, 32'd1024, 32'd0, 1, 0);
    access(1, 0, 1, 32'd1024, 32'd0, 0, 0);
    access(1, 0, 1, 32'd1028, 32'd0, 1, 0);

    for (int i = 0; i < 60; i++) begin
      s  = 1'($urandom_range(0, 1));
      op = $urandom_range(0, 2);
      if ($urandom_range(0, 5) == 0) a = BASE - 32'd4 + 32'($urandom_range(0, 3));
      else begin
        k = $urandom_range(0, 12);
        a = BASE + 32'(k * 4) + 32'($urandom_range(0, 3));
      end
      access(s, op != 1, op != 0, a, $urandom, 1'($urandom_range(0, 1)), 0);
    end
    idle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
